// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file (regfile_mp).
package regfile_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_t;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int NUM_RD_DEF   = 2;
  localparam int NUM_WR_DEF   = 2;
  localparam int ZERO_REG_DEF = 1;

  // Upper bound on write ports the priority helper can handle.
  localparam int MAX_WR = 16;

  // Index of the highest set bit in mask (0 when mask is empty).
  // Higher port index always wins, so scanning upward keeps the last hit.
  function automatic int unsigned prio_sel(input logic [MAX_WR-1:0] mask);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_WR; i++) begin
      if (mask[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

  // Width of a port index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bus of the register file: read ports, write ports,
// readiness and last-write debug probe. slave = register file, master = user.
interface regfile_mp_if #(
  parameter int DATA_W = regfile_pkg::DATA_W_DEF,
  parameter int ADDR_W = regfile_pkg::ADDR_W_DEF,
  parameter int NUM_RD = regfile_pkg::NUM_RD_DEF,
  parameter int NUM_WR = regfile_pkg::NUM_WR_DEF
) ();

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     ready;
  logic [ADDR_W-1:0]        probe_addr;
  logic [DATA_W-1:0]        probe_data;
  logic [15:0]              wr_count;

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data,
    output rd_data, ready, probe_addr, probe_data, wr_count
  );

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data, ready, probe_addr, probe_data, wr_count
  );

endinterface

// File: rtl/regfile_wr_arb.sv
// Write-port arbiter: drops zero-register writes, resolves same-address
// conflicts (highest enabled port index wins) and reports the surviving
// commit mask, the highest-index committing port and the commit count.
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter  int ADDR_W   = ADDR_W_DEF,
  parameter  int NUM_WR   = NUM_WR_DEF,
  parameter  int ZERO_REG = ZERO_REG_DEF,
  localparam int IDX_W    = regfile_pkg::idx_w(NUM_WR),
  localparam int CNT_W    = $clog2(NUM_WR + 1)
) (
  input  logic [NUM_WR-1:0]        en_i,
  input  logic [NUM_WR*ADDR_W-1:0] addr_i,
  output logic [NUM_WR-1:0]        commit_o,
  output logic [IDX_W-1:0]         winner_o,
  output logic [CNT_W-1:0]         count_o,
  output logic                     any_o
);

  logic [ADDR_W-1:0] addr [NUM_WR];

  for (genvar j = 0; j < NUM_WR; j++) begin : g_addr
    assign addr[j] = addr_i[j*ADDR_W +: ADDR_W];
  end

  // A port commits unless it targets the zero register or a higher port
  // is also writing the same address this cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    commit_o = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      commit_o[j] = en_i[j] && !((ZERO_REG != 0) && (addr[j] == '0));
      for (int i = j + 1; i < NUM_WR; i++) begin
        if (en_i[i] && (addr[i] == addr[j])) commit_o[j] = 1'b0;
      end
    end
  end

  // Surviving ports all target distinct addresses, so the popcount is the
  // number of registers updated this cycle.
  always_comb begin
    count_o = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      count_o = count_o + CNT_W'(commit_o[j]);
    end
  end

  assign any_o    = |commit_o;
  assign winner_o = IDX_W'(prio_sel(MAX_WR'(commit_o)));

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file for the MIPS datapath.
// After reset a sweep loads register[i] = i (one register per cycle), then
// ready rises and the file serves combinational reads and prioritised writes.
// Optional build macro: REGFILE_BYPASS_EN enables write-to-read forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int NUM_WR   = NUM_WR_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int IDX_W = regfile_pkg::idx_w(NUM_WR);
  localparam int CNT_W = $clog2(NUM_WR + 1);

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] init_idx_q, init_idx_d;
  logic              run, init_we;

  logic [ADDR_W-1:0] probe_addr_q, probe_addr_d;
  logic [DATA_W-1:0] probe_data_q, probe_data_d;
  logic [15:0]       wr_count_q, wr_count_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] ra [NUM_RD];
  logic [ADDR_W-1:0] wa [NUM_WR];
  logic [DATA_W-1:0] wd [NUM_WR];
  logic [NUM_RD*DATA_W-1:0] rd_flat;

  logic [NUM_WR-1:0] arb_en, commit;
  logic [IDX_W-1:0]  winner;
  logic [CNT_W-1:0]  commit_cnt;
  logic              commit_any;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_unpack
    assign ra[k] = bus.rd_addr[k*ADDR_W +: ADDR_W];
  end

  for (genvar j = 0; j < NUM_WR; j++) begin : g_wr_unpack
    assign wa[j] = bus.wr_addr[j*ADDR_W +: ADDR_W];
    assign wd[j] = bus.wr_data[j*DATA_W +: DATA_W];
  end

  // FSM state register: sweep state and index restart on reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state_q    <= INIT;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  // FSM next state: walk every address once, then settle in RUN.
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    case (state_q)
      INIT: begin
        init_idx_d = init_idx_q + ADDR_W'(1);
        if (init_idx_q == ADDR_W'(DEPTH - 1)) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // FSM outputs: sweep write strobe and run/ready flag.
  always_comb begin
    run     = (state_q == RUN);
    init_we = (state_q == INIT);
  end

  // No write is allowed to commit during the sweep or a reset cycle.
  assign arb_en = bus.wr_en & {NUM_WR{run && rst}};

  regfile_wr_arb #(
    .ADDR_W   (ADDR_W),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_wr_arb (
    .en_i     (arb_en),
    .addr_i   (bus.wr_addr),
    .commit_o (commit),
    .winner_o (winner),
    .count_o  (commit_cnt),
    .any_o    (commit_any)
  );

  // Probe/counter next state: follow the winning write, hold otherwise.
  always_comb begin
    probe_addr_d = probe_addr_q;
    probe_data_d = probe_data_q;
    wr_count_d   = wr_count_q + 16'(commit_cnt);
    if (commit_any) begin
      probe_addr_d = wa[winner];
      probe_data_d = wd[winner];
    end
  end

  // Probe/counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      probe_addr_q <= '0;
      probe_data_q <= '0;
      wr_count_q   <= '0;
    end else begin
      probe_addr_q <= probe_addr_d;
      probe_data_q <= probe_data_d;
      wr_count_q   <= wr_count_d;
    end
  end

  // Storage array: sweep initialisation or arbitrated writes.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset branch; the init sweep gives it known contents.
    if (rst) begin
      if (init_we) mem_q[init_idx_q] <= DATA_W'(init_idx_q);
      for (int j = 0; j < NUM_WR; j++) begin
        if (commit[j]) mem_q[wa[j]] <= wd[j];
      end
    end
  end

  // Read ports: zero during the sweep, zero register, optional forwarding.
  always_comb begin
    rd_flat = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (run && !((ZERO_REG != 0) && (ra[k] == '0))) begin
        rd_flat[k*DATA_W +: DATA_W] = mem_q[ra[k]];
`ifdef REGFILE_BYPASS_EN
        // Committing ports have distinct addresses, so at most one matches.
        for (int j = 0; j < NUM_WR; j++) begin
          if (commit[j] && (wa[j] == ra[k])) rd_flat[k*DATA_W +: DATA_W] = wd[j];
        end
`else
        // Same-cycle writes are not forwarded; reads see the pre-edge value.
`endif
      end
    end
  end

  assign bus.rd_data    = rd_flat;
  assign bus.ready      = run;
  assign bus.probe_addr = probe_addr_q;
  assign bus.probe_data = probe_data_q;
  assign bus.wr_count   = wr_count_q;

endmodule
